timer_ctrl: RTL

//   Sequencer for a cascade of NDIG BCD digit counters (0..9, ena_i/updown_i, async rst_ni).

---
 rtl/timer_ctrl_pkg.sv | 8 +
 rtl/timer_ctrl_if.sv | 16 +
 rtl/timer_prescaler.sv | 18 +
 rtl/timer_ctrl.sv | 77 +++++++
 4 files changed

// File: rtl/timer_ctrl_pkg.sv
// timer_ctrl_pkg: shared state encoding and digit/direction constants for the timer sequencer
package timer_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;
  localparam logic [3:0] DIG_MAX = 4'd9;
  localparam logic [3:0] DIG_MIN = 4'd0;
  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DOWN = 1'b0;
endpackage

// File: rtl/timer_ctrl_if.sv
// timer_ctrl_if: command inputs, digit feedback and counter-control outputs of the timer sequencer
interface timer_ctrl_if #(parameter int NDIG = 2);
  logic start;
  logic pause;
  logic clear;
  logic dir;
  logic [4*NDIG-1:0] dig;
  logic [NDIG-1:0] ena;
  logic updown;
  logic cnt_rst_n;
  logic running;
  logic done;
  logic tc;
  modport master(output start, pause, clear, dir, dig, input ena, updown, cnt_rst_n, running, done, tc);
  modport slave(input start, pause, clear, dir, dig, output ena, updown, cnt_rst_n, running, done, tc);
endinterface

// File: rtl/timer_prescaler.sv
// timer_prescaler: counts 0..PRESCALE-1 while run is high and flags the last value as a tick
module timer_prescaler #(
  parameter int PRESCALE = 50_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic clear,
  output logic tick
);
  localparam int W = $clog2(PRESCALE);
  localparam logic [W-1:0] LAST = W'(PRESCALE - 1);
  logic [W-1:0] cnt;
  assign tick = run && cnt == LAST;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else cnt <= clear ? '0 : run ? (tick ? '0 : cnt + 1'b1) : cnt;
endmodule

// File: rtl/timer_ctrl.sv
// timer_ctrl: start/pause/clear sequencer and cascade-enable generator for NDIG BCD digit counters
// Define TIMER_CTRL_WRAP_EN to let the cascade wrap on terminal count instead of stopping in DONE.
module timer_ctrl
  import timer_ctrl_pkg::*;
#(
  parameter int NDIG = 2,
  parameter int PRESCALE = 50_000_000
) (
  input logic clk,
  input logic rst_n,
  timer_ctrl_if.slave bus
);
  state_t state_q, state_d;
  logic [NDIG-1:0] ena_q, ena_d, casc;
  logic updown_q, updown_d, cnt_rst_q, running_q, done_q, tc_q, tc_d, tick, term;
  logic [3:0] bnd;
  timer_prescaler #(.PRESCALE(PRESCALE)) u_pre (
    .clk(clk), .rst_n(rst_n), .run(state_q == RUN), .clear(bus.clear), .tick(tick)
  );
  assign bnd = updown_q == DIR_UP ? DIG_MAX : DIG_MIN;
  // term doubles as the running "all lower digits at boundary" prefix
  always_comb begin
    term = 1'b1;
    casc = '0;
    for (int k = 0; k < NDIG; k++) begin
      casc[k] = term;
      term = term && bus.dig[4*k+:4] == bnd;
    end
  end
  always_comb begin
    state_d = state_q;
    updown_d = updown_q;
    ena_d = '0;
    tc_d = 1'b0;
    if (bus.clear) state_d = IDLE;
    else begin
      if (bus.pause && state_q == RUN) state_d = PAUSE;
      else if (bus.start && (state_q == IDLE || state_q == PAUSE)) begin
        state_d = RUN;
        updown_d = bus.dir;
      end
      if (tick) begin
        tc_d = term;
`ifdef TIMER_CTRL_WRAP_EN
        ena_d = casc;
`else
        ena_d = term ? '0 : casc;
        state_d = term ? DONE : state_d;
`endif
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      ena_q <= '0;
      updown_q <= DIR_UP;
      cnt_rst_q <= 1'b0;
      running_q <= 1'b0;
      done_q <= 1'b0;
      tc_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ena_q <= ena_d;
      updown_q <= updown_d;
      cnt_rst_q <= !bus.clear;
      running_q <= state_d == RUN;
      done_q <= state_d == DONE;
      tc_q <= tc_d;
    end
  assign bus.ena = ena_q;
  assign bus.updown = updown_q;
  assign bus.cnt_rst_n = cnt_rst_q;
  assign bus.running = running_q;
  assign bus.done = done_q;
  assign bus.tc = tc_q;
endmodule
